// File: rtl/hci_mem_pipe.sv
`default_nettype none
// ============================================================================
// hci_mem_pipe : TCDM request/response pipeline stage with optional cuts
// Revision     : 1.0 - initial release
// ============================================================================
module hci_mem_pipe #(
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 32,
    parameter int unsigned IW      = 8,
    parameter int unsigned UW      = 1,
    parameter int unsigned REQ_CUT = 1,
    parameter int unsigned RSP_CUT = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,

    input  logic              tcdm_slave_req,
    output logic              tcdm_slave_gnt,
    input  logic [AW-1:0]     tcdm_slave_add,
    input  logic              tcdm_slave_we_n,
    input  logic [DW-1:0]     tcdm_slave_data,
    input  logic [DW/8-1:0]   tcdm_slave_be,
    input  logic [IW-1:0]     tcdm_slave_id,
    input  logic [UW-1:0]     tcdm_slave_user,
    output logic              tcdm_slave_r_valid,
    output logic [DW-1:0]     tcdm_slave_r_data,
    output logic [IW-1:0]     tcdm_slave_r_id,
    output logic [UW-1:0]     tcdm_slave_r_user,

    output logic              tcdm_master_req,
    input  logic              tcdm_master_gnt,
    output logic [AW-1:0]     tcdm_master_add,
    output logic              tcdm_master_we_n,
    output logic [DW-1:0]     tcdm_master_data,
    output logic [DW/8-1:0]   tcdm_master_be,
    output logic [IW-1:0]     tcdm_master_id,
    output logic [UW-1:0]     tcdm_master_user,
    input  logic              tcdm_master_r_valid,
    input  logic [DW-1:0]     tcdm_master_r_data,
    input  logic [IW-1:0]     tcdm_master_r_id,
    input  logic [UW-1:0]     tcdm_master_r_user
);

    localparam int unsigned BW = DW / 8;
    localparam int unsigned PW = AW + 1 + DW + BW + IW + UW;

    if (DW % 8 != 0) begin : g_dw_check
        $error("hci_mem_pipe: DW must be a multiple of 8");
    end

    logic [PW-1:0] slave_pl;
    logic [PW-1:0] master_pl;

    assign slave_pl = {tcdm_slave_add, tcdm_slave_we_n, tcdm_slave_data,
                       tcdm_slave_be, tcdm_slave_id, tcdm_slave_user};
    assign {tcdm_master_add, tcdm_master_we_n, tcdm_master_data,
            tcdm_master_be, tcdm_master_id, tcdm_master_user} = master_pl;

    if (REQ_CUT != 0) begin : g_req_cut
        // head is always the oldest entry, so the master side reads registers only
        logic [1:0]    cnt;
        logic [PW-1:0] head;
        logic [PW-1:0] tail;
        logic          push;
        logic          pop;

        assign tcdm_slave_gnt  = (cnt != 2'd2);
        assign tcdm_master_req = (cnt != 2'd0);
        assign master_pl       = head;
        assign push            = tcdm_slave_req & tcdm_slave_gnt;
        assign pop             = tcdm_master_req & tcdm_master_gnt;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt  <= 2'd0;
                head <= '0;
                tail <= '0;
            end else if (clear_i) begin
                cnt <= 2'd0;
            end else begin
                case ({push, pop})
                    2'b10: begin
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd0) begin
                            head <= slave_pl;
                        end else begin
                            tail <= slave_pl;
                        end
                    end
                    2'b01: begin
                        cnt  <= cnt - 2'd1;
                        head <= tail;
                    end
                    // simultaneous push/pop only happens at cnt==1: new entry becomes head
                    2'b11: begin
                        head <= slave_pl;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end else begin : g_req_wire
        assign tcdm_master_req = tcdm_slave_req;
        assign tcdm_slave_gnt  = tcdm_master_gnt;
        assign master_pl       = slave_pl;
    end

    if (RSP_CUT != 0) begin : g_rsp_cut
        logic          r_valid_q;
        logic [DW-1:0] r_data_q;
        logic [IW-1:0] r_id_q;
        logic [UW-1:0] r_user_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_valid_q <= 1'b0;
                r_data_q  <= '0;
                r_id_q    <= '0;
                r_user_q  <= '0;
            end else if (clear_i) begin
                r_valid_q <= 1'b0;
            end else begin
                r_valid_q <= tcdm_master_r_valid;
                if (tcdm_master_r_valid) begin
                    r_data_q <= tcdm_master_r_data;
                    r_id_q   <= tcdm_master_r_id;
                    r_user_q <= tcdm_master_r_user;
                end
            end
        end

        assign tcdm_slave_r_valid = r_valid_q;
        assign tcdm_slave_r_data  = r_data_q;
        assign tcdm_slave_r_id    = r_id_q;
        assign tcdm_slave_r_user  = r_user_q;
    end else begin : g_rsp_wire
        assign tcdm_slave_r_valid = tcdm_master_r_valid;
        assign tcdm_slave_r_data  = tcdm_master_r_data;
        assign tcdm_slave_r_id    = tcdm_master_r_id;
        assign tcdm_slave_r_user  = tcdm_master_r_user;
    end

endmodule
`default_nettype wire

// File: tb/tb_hci_mem_pipe.sv
`default_nettype none
// ============================================================================
// tb_hci_mem_pipe : directed and random checks of hci_mem_pipe (cut and wire)
// Revision        : 1.0 - initial release
// ============================================================================
module tb_hci_mem_pipe;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned IW = 8;
    localparam int unsigned UW = 1;
    localparam int unsigned BW = DW / 8;
    localparam int unsigned PW = AW + 1 + DW + BW + IW + UW;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic clear_i = 1'b0;
    always #5 clk = ~clk;

    logic          s_req = 1'b0;
    logic [AW-1:0] s_add = '0;
    logic          s_we_n = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic [BW-1:0] s_be = '0;
    logic [IW-1:0] s_id = '0;
    logic [UW-1:0] s_user = '0;
    logic          m_gnt = 1'b0;
    logic          m_rv = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic [IW-1:0] m_rid = '0;
    logic [UW-1:0] m_ruser = '0;

    // registered instance outputs
    logic          c_sgnt, c_mreq, c_mwe, c_rv;
    logic [AW-1:0] c_madd;
    logic [DW-1:0] c_mdata, c_rdata;
    logic [BW-1:0] c_mbe;
    logic [IW-1:0] c_mid, c_rid;
    logic [UW-1:0] c_muser, c_ruser;
    // pass-through instance outputs
    logic          w_sgnt, w_mreq, w_mwe, w_rv;
    logic [AW-1:0] w_madd;
    logic [DW-1:0] w_mdata, w_rdata;
    logic [BW-1:0] w_mbe;
    logic [IW-1:0] w_mid, w_rid;
    logic [UW-1:0] w_muser, w_ruser;

    hci_mem_pipe #(.DW(DW), .AW(AW), .IW(IW), .UW(UW), .REQ_CUT(1), .RSP_CUT(1)) u_cut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
        .tcdm_slave_req(s_req), .tcdm_slave_gnt(c_sgnt), .tcdm_slave_add(s_add),
        .tcdm_slave_we_n(s_we_n), .tcdm_slave_data(s_data), .tcdm_slave_be(s_be),
        .tcdm_slave_id(s_id), .tcdm_slave_user(s_user),
        .tcdm_slave_r_valid(c_rv), .tcdm_slave_r_data(c_rdata), .tcdm_slave_r_id(c_rid),
        .tcdm_slave_r_user(c_ruser),
        .tcdm_master_req(c_mreq), .tcdm_master_gnt(m_gnt), .tcdm_master_add(c_madd),
        .tcdm_master_we_n(c_mwe), .tcdm_master_data(c_mdata), .tcdm_master_be(c_mbe),
        .tcdm_master_id(c_mid), .tcdm_master_user(c_muser),
        .tcdm_master_r_valid(m_rv), .tcdm_master_r_data(m_rdata), .tcdm_master_r_id(m_rid),
        .tcdm_master_r_user(m_ruser)
    );

    hci_mem_pipe #(.DW(DW), .AW(AW), .IW(IW), .UW(UW), .REQ_CUT(0), .RSP_CUT(0)) u_pass (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
        .tcdm_slave_req(s_req), .tcdm_slave_gnt(w_sgnt), .tcdm_slave_add(s_add),
        .tcdm_slave_we_n(s_we_n), .tcdm_slave_data(s_data), .tcdm_slave_be(s_be),
        .tcdm_slave_id(s_id), .tcdm_slave_user(s_user),
        .tcdm_slave_r_valid(w_rv), .tcdm_slave_r_data(w_rdata), .tcdm_slave_r_id(w_rid),
        .tcdm_slave_r_user(w_ruser),
        .tcdm_master_req(w_mreq), .tcdm_master_gnt(m_gnt), .tcdm_master_add(w_madd),
        .tcdm_master_we_n(w_mwe), .tcdm_master_data(w_mdata), .tcdm_master_be(w_mbe),
        .tcdm_master_id(w_mid), .tcdm_master_user(w_muser),
        .tcdm_master_r_valid(m_rv), .tcdm_master_r_data(m_rdata), .tcdm_master_r_id(m_rid),
        .tcdm_master_r_user(m_ruser)
    );

    int passed = 0;
    int total  = 0;

    // reference model: FIFO of accepted requests (capacity 2) and last response
    logic [PW-1:0] q[$];
    logic          exp_rv = 1'b0;
    logic [DW-1:0] exp_rdata = '0;
    logic [IW-1:0] exp_rid = '0;
    logic [UW-1:0] exp_ruser = '0;
    logic [IW-1:0] popped_ids[$];
    int            pop_cycles[$];
    int            cyc = 0;
    int            max_occ = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [PW-1:0] mk(input logic [AW-1:0] a, input logic we,
                                         input logic [DW-1:0] d, input logic [BW-1:0] b,
                                         input logic [IW-1:0] id, input logic [UW-1:0] u);
        return {a, we, d, b, id, u};
    endfunction

    // one clock cycle: drive at negedge, check, advance model at posedge
    task automatic cycle(input logic sreq, input logic [PW-1:0] spl, input logic mgnt,
                         input logic mrv, input logic [DW-1:0] rd, input logic [IW-1:0] rid,
                         input logic [UW-1:0] ru, input logic clr);
        logic push, pop;
        s_req = sreq;
        {s_add, s_we_n, s_data, s_be, s_id, s_user} = spl;
        m_gnt = mgnt; m_rv = mrv; m_rdata = rd; m_rid = rid; m_ruser = ru;
        clear_i = clr;
        #1;
        check("slave_gnt", c_sgnt, q.size() < 2);
        check("master_req", c_mreq, q.size() > 0);
        if (q.size() > 0)
            check("master_payload", {c_madd, c_mwe, c_mdata, c_mbe, c_mid, c_muser}, q[0]);
        check("r_valid", c_rv, exp_rv);
        check("r_payload", {c_rdata, c_rid, c_ruser}, {exp_rdata, exp_rid, exp_ruser});
        check("wire_req", {w_mreq, w_madd, w_mwe, w_mdata, w_mbe, w_mid, w_muser}, {sreq, spl});
        check("wire_rsp", {w_sgnt, w_rv, w_rdata, w_rid, w_ruser}, {mgnt, mrv, rd, rid, ru});
        push = sreq && (q.size() < 2);
        pop  = (q.size() > 0) && mgnt;
        @(posedge clk);
        cyc++;
        if (clr) begin
            q.delete();
            exp_rv = 1'b0;
        end else begin
            if (pop) begin
                popped_ids.push_back(q[0][IW:1]);
                pop_cycles.push_back(cyc);
                void'(q.pop_front());
            end
            if (push) q.push_back(spl);
            exp_rv = mrv;
            if (mrv) begin
                exp_rdata = rd; exp_rid = rid; exp_ruser = ru;
            end
        end
        if (q.size() > max_occ) max_occ = q.size();
        @(negedge clk);
    endtask

    task automatic idle(input logic mgnt);
        cycle(1'b0, '0, mgnt, 1'b0, '0, '0, '0, 1'b0);
    endtask

    initial begin
        logic [PW-1:0] pl;
        logic [95:0]   rnd;
        logic          hold_req;
        logic [PW-1:0] hold_pl;

        // asynchronous reset values before any clock edge
        #2;
        check("rst_slave_gnt", c_sgnt, 1'b1);
        check("rst_master_req", c_mreq, 1'b0);
        check("rst_master_pl", {c_madd, c_mdata, c_mid}, '0);
        check("rst_r_valid", c_rv, 1'b0);
        check("rst_r_data", c_rdata, '0);
        @(negedge clk);
        rst_ni = 1'b1;

        // single write, then payload visible one cycle later
        pl = mk(32'h100, 1'b0, 32'hDEADBEEF, 4'hF, 8'h11, 1'b0);
        cycle(1'b1, pl, 1'b1, 1'b0, '0, '0, '0, 1'b0);
        #1;
        check("single_req", c_mreq, 1'b1);
        check("single_add", c_madd, 32'h100);
        check("single_data", c_mdata, 32'hDEADBEEF);
        check("single_gnt", c_sgnt, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // back-pressure with ids 1,2,3
        popped_ids.delete();
        cycle(1'b1, mk(32'h10, 1'b0, 32'h1, 4'hF, 8'd1, 1'b0), 1'b0, 1'b0, '0, '0, '0, 1'b0);
        cycle(1'b1, mk(32'h20, 1'b1, 32'h2, 4'h3, 8'd2, 1'b1), 1'b0, 1'b0, '0, '0, '0, 1'b0);
        #1;
        check("bp_gnt_full", c_sgnt, 1'b0);
        pl = mk(32'h30, 1'b0, 32'h3, 4'hC, 8'd3, 1'b0);
        cycle(1'b1, pl, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        cycle(1'b1, pl, 1'b1, 1'b0, '0, '0, '0, 1'b0);
        #1;
        check("bp_gnt_after_pop", c_sgnt, 1'b1);
        cycle(1'b1, pl, 1'b1, 1'b0, '0, '0, '0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        check("bp_count", popped_ids.size(), 3);
        check("bp_order", {popped_ids[0], popped_ids[1], popped_ids[2]}, {8'd1, 8'd2, 8'd3});

        // streaming 16 requests with master_gnt held high
        pop_cycles.delete();
        max_occ = 0;
        for (int i = 0; i < 16; i++)
            cycle(1'b1, mk(32'h1000 + i * 4, 1'b0, $urandom, 4'hF, 8'(i + 32), 1'b0),
                  1'b1, 1'b0, '0, '0, '0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        check("stream_count", pop_cycles.size(), 16);
        check("stream_span", pop_cycles[15] - pop_cycles[0], 15);
        check("stream_max_cnt", max_occ, 1);

        // one-cycle response
        cycle(1'b0, '0, 1'b1, 1'b1, 32'hCAFEF00D, 8'd5, 1'b1, 1'b0);
        #1;
        check("rsp_valid", c_rv, 1'b1);
        check("rsp_data", {c_rdata, c_rid}, {32'hCAFEF00D, 8'd5});
        idle(1'b1);
        #1;
        check("rsp_valid_after", c_rv, 1'b0);

        // flush with two buffered entries and a concurrent push
        cycle(1'b1, mk(32'hA0, 1'b0, 32'hA, 4'hF, 8'hA0, 1'b0), 1'b0, 1'b0, '0, '0, '0, 1'b0);
        cycle(1'b1, mk(32'hB0, 1'b0, 32'hB, 4'hF, 8'hB0, 1'b0), 1'b0, 1'b0, '0, '0, '0, 1'b0);
        cycle(1'b1, mk(32'hC0, 1'b0, 32'hC, 4'hF, 8'hC0, 1'b0), 1'b1, 1'b1, 32'h77, 8'd7, '0, 1'b1);
        #1;
        check("flush_master_req", c_mreq, 1'b0);
        check("flush_r_valid", c_rv, 1'b0);
        idle(1'b1);

        // reset pulsed mid-cycle with buffered entries and pending response
        cycle(1'b1, mk(32'hD0, 1'b0, 32'hD, 4'hF, 8'hD0, 1'b0), 1'b0, 1'b0, '0, '0, '0, 1'b0);
        cycle(1'b1, mk(32'hE0, 1'b0, 32'hE, 4'hF, 8'hE0, 1'b0), 1'b0, 1'b1, 32'h55, 8'd9, 1'b1, 1'b0);
        s_req = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        check("mid_rst_master_req", c_mreq, 1'b0);
        check("mid_rst_slave_gnt", c_sgnt, 1'b1);
        check("mid_rst_r_valid", c_rv, 1'b0);
        check("mid_rst_payload", {c_madd, c_mdata, c_rdata, c_rid}, '0);
        #1 rst_ni = 1'b1;
        q.delete();
        exp_rv = 1'b0; exp_rdata = '0; exp_rid = '0; exp_ruser = '0;
        idle(1'b0);
        idle(1'b1);

        // random traffic honouring the hold-until-granted rule
        hold_req = 1'b0;
        hold_pl  = '0;
        for (int i = 0; i < 300; i++) begin
            logic r, c, g, rv;
            c = ($urandom_range(0, 19) == 0);
            if (hold_req) begin
                r  = 1'b1;
                pl = hold_pl;
            end else begin
                r   = ($urandom_range(0, 2) != 0);
                rnd = {$urandom, $urandom, $urandom};
                pl  = rnd[PW-1:0];
            end
            g  = ($urandom_range(0, 3) != 0);
            rv = ($urandom_range(0, 1) != 0);
            hold_req = r && (q.size() >= 2);
            hold_pl  = pl;
            cycle(r, pl, g, rv, $urandom, 8'($urandom), 1'($urandom), c);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hci_mem_pipe.md
HCI_MEM_PIPE -- requirements
Module: hci_mem_pipe

Interface
REQ-001 Parameters SHALL be: DW 32 (data width); AW 32 (address width); IW 8 (id width); UW 1 (user width); REQ_CUT 1 (1 = registered request path, 0 = wire); RSP_CUT 1 (1 = registered response path, 0 = wire).
REQ-002 Byte-enable width SHALL be BW = DW/8, and elaboration SHALL fail if DW is not a multiple of 8.
REQ-003 The ports SHALL be as follows; the single clock is clk_i, and reset is rst_ni, asynchronous and active-low:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous flush
- tcdm_slave_req  in  1  upstream request
- tcdm_slave_gnt  out  1  upstream grant
- tcdm_slave_add/we_n/data/be/id/user  in  AW/1/DW/BW/IW/UW  upstream request payload
- tcdm_slave_r_valid  out  1  upstream response valid
- tcdm_slave_r_data/r_id/r_user  out  DW/IW/UW  upstream response payload
- tcdm_master_req  out  1  downstream request
- tcdm_master_gnt  in  1  downstream grant
- tcdm_master_add/we_n/data/be/id/user  out  AW/1/DW/BW/IW/UW  downstream request payload
- tcdm_master_r_valid  in  1  downstream response valid
- tcdm_master_r_data/r_id/r_user  in  DW/IW/UW  downstream response payload

Function
REQ-004 Handshake: a request transfers on any edge where req=1 and gnt=1 on that side.
REQ-005 Once req is asserted, the requester SHALL hold req and its payload stable until granted; the block SHALL obey the same rule on its master side.
REQ-006 When REQ_CUT=0, every request signal SHALL be a pure wire: master_req=slave_req, slave_gnt=master_gnt, master payload=slave payload.
REQ-007 When REQ_CUT=1, the request path SHALL be a 2-entry in-order spill buffer with an occupancy counter cnt ranging 0..2.
REQ-008 With REQ_CUT=1, tcdm_slave_gnt SHALL equal (cnt<2), a function of state only, with no combinational path from tcdm_master_gnt.
REQ-009 With REQ_CUT=1, a push occurs on a slave handshake, and the slave payload (add, we_n, data, be, id, user) is written into the tail entry.
REQ-010 With REQ_CUT=1, tcdm_master_req SHALL equal (cnt>0), and the master payload SHALL be the head entry, driven from registers only.
REQ-011 With REQ_CUT=1, a pop occurs on a master handshake and removes the head entry.
REQ-012 Occupancy SHALL update as: push only, cnt+1; pop only, cnt-1; push and pop together (possible only when cnt=1), cnt unchanged with the new entry becoming head next cycle.
REQ-013 There SHALL be no empty-bypass: request latency is exactly 1 cycle from slave handshake to master_req when the buffer is empty.
REQ-014 Sustained throughput SHALL be 1 request/cycle whenever master_gnt is held at 1.
REQ-015 Entries SHALL leave the buffer in arrival order, with no reordering, duplication or loss.
REQ-016 When RSP_CUT=0, the response path SHALL be a wire: slave_r_valid=master_r_valid and slave_r_* = master_r_*.
REQ-017 When RSP_CUT=1, the response registers SHALL capture master_r_valid every cycle, and capture r_data/r_id/r_user only when master_r_valid=1, otherwise holding their value.
REQ-018 With RSP_CUT=1, response latency SHALL be exactly 1 cycle, and responses are never stalled (no r_ready).
REQ-019 clear_i=1 SHALL set cnt to 0 and the response valid register to 0 on the next edge, discarding buffered entries.
REQ-020 clear_i SHALL take priority over a simultaneous push, pop or response capture.
REQ-021 While clear_i=1, slave_gnt SHALL still follow REQ-008, but a push on that edge SHALL be dropped.
REQ-022 Payload registers SHALL NOT be cleared by clear_i.

Reset
REQ-023 On rst_ni=0 the block SHALL asynchronously force: cnt=0; tcdm_master_req=0; tcdm_slave_gnt=1 (REQ_CUT=1); tcdm_slave_r_valid=0 (RSP_CUT=1); all payload and response registers to 0.
REQ-024 Reset asserted mid-transfer SHALL drop all buffered requests and any pending registered response, with no master_req pulse after release until a new slave push.
REQ-025 After rst_ni deasserts, the block SHALL be fully operational on the first clock edge.

Verification
REQ-026 Single write (REQ_CUT=1, RSP_CUT=1), add=0x100, data=0xDEADBEEF, be=0xF, we_n=0, master_gnt=1 -> master_req=1 with identical payload at cycle+1, and slave_gnt stays 1.
REQ-027 Back-pressure: master_gnt=0 while 3 back-to-back requests id=1,2,3 are offered -> ids 1,2 accepted, slave_gnt=0 when cnt=2; then master_gnt=1 -> order 1,2,3 at master, with id 3 granted the cycle after cnt falls to 1.
REQ-028 Streaming: 16 requests with master_gnt=1 constantly -> 16 master handshakes on 16 consecutive cycles, and cnt never exceeds 1.
REQ-029 Response: master_r_valid=1, r_data=0xCAFEF00D, r_id=5 for one cycle -> slave_r_valid=1 with the same values exactly one cycle later, and 0 after.
REQ-030 Flush/reset: cnt=2 then clear_i=1 concurrent with a push -> cnt=0 and master_req=0 next cycle; repeating with rst_ni pulsed low mid-cycle -> all outputs at REQ-023 values immediately.
REQ-031 Pass-through: REQ_CUT=0 and RSP_CUT=0 -> all outputs equal the corresponding inputs in the same cycle under random stimulus.
